// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

  localparam int N_DEF     = 8;
  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 2;
  localparam int CW_DEF    = 8;

  // Default saturation ceiling of the grant counter (2^CW - 1).
  localparam int GRANT_CNT_MAX = (1 << CW_DEF) - 1;

  // Index to one-hot; callers keep the low bits they need (up to 16 targets).
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side and bank-side signals shared between the arbiter and its neighbours.
interface reg_write_arbiter_if
  import reg_write_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int CW    = CW_DEF
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*N-1:0]  wdata;
  logic [NREQ-1:0]    gnt;
  logic [DEPTH-1:0]   en;
  logic [N-1:0]       d;
  logic [CW-1:0]      grant_cnt;
  logic               busy;

  modport master (
    output req, addr, wdata,
    input  gnt, en, d, grant_cnt, busy
  );

  modport slave (
    input  req, addr, wdata,
    output gnt, en, d, grant_cnt, busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            valid
);

  // Scan from the farthest offset back to ptr so the closest eligible index wins.
  always_comb begin
    int sum_s;
    int idx_s;
    win   = '0;
    valid = 1'b0;
    sum_s = 0;
    idx_s = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s = int'(ptr) + k;
      idx_s = (sum_s >= NREQ) ? (sum_s - NREQ) : sum_s;
      win   = elig[idx_s] ? PW'(idx_s) : win;
      valid = valid | elig[idx_s];
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving a shared register bank's one-hot enable and data bus.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  reg_write_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [NREQ-1:0]  gnt_r;
  logic [DEPTH-1:0] en_r;
  logic [N-1:0]     d_r;
  logic [CW-1:0]    cnt_r;
  logic [PW-1:0]    ptr_r;

  logic [NREQ-1:0]  elig_s;
  logic [PW-1:0]    win_s;
  logic             win_vld_s;
  logic [AW-1:0]    waddr_s;
  logic [15:0]      gnt_oh_s;
  logic [15:0]      en_oh_s;
  logic [NREQ-1:0]  gnt_next_s;
  logic [DEPTH-1:0] en_next_s;
  logic [N-1:0]     d_next_s;
  logic [PW-1:0]    ptr_next_s;
  logic [CW-1:0]    cnt_next_s;

  // Last cycle's grant is masked so a held request is never granted twice.
  assign elig_s = bus.req & ~gnt_r;

  rr_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig  (elig_s),
    .ptr   (ptr_r),
    .win   (win_s),
    .valid (win_vld_s)
  );

  // Next-state values for grant, enable, data, pointer and counter.
  always_comb begin
    waddr_s    = bus.addr[int'(win_s)*AW +: AW];
    d_next_s   = bus.wdata[int'(win_s)*N +: N];
    gnt_oh_s   = onehot16(4'(win_s));
    en_oh_s    = onehot16(4'(waddr_s));
    gnt_next_s = '0;
    en_next_s  = '0;
    if (win_vld_s) begin
      gnt_next_s = gnt_oh_s[NREQ-1:0];
      en_next_s  = en_oh_s[DEPTH-1:0];
    end else begin
      gnt_next_s = '0;
      en_next_s  = '0;
    end
    if (int'(win_s) == NREQ - 1) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_s + PW'(1);
    end
    if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  // Output, pointer and counter registers; d and ptr hold when nothing is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_r <= '0;
      en_r  <= '0;
      d_r   <= '0;
      cnt_r <= '0;
      ptr_r <= '0;
    end else begin
      gnt_r <= gnt_next_s;
      en_r  <= en_next_s;
      if (win_vld_s) begin
        d_r   <= d_next_s;
        ptr_r <= ptr_next_s;
        cnt_r <= cnt_next_s;
      end
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.en        = en_r;
  assign bus.d         = d_r;
  assign bus.grant_cnt = cnt_r;
  assign bus.busy      = |elig_s;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: default instance plus a CW=3 instance for saturation.
module tb_reg_write_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] bank [4];
  logic [3:0] exp_g [5];
  logic [7:0] exp_d [5];

  reg_write_arbiter_if #(.CW(8)) bus ();
  reg_write_arbiter_if #(.CW(3)) bus_s ();

  assign bus_s.req   = bus.req;
  assign bus_s.addr  = bus.addr;
  assign bus_s.wdata = bus.wdata;

  reg_write_arbiter #(.CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  reg_write_arbiter #(.CW(3)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference register bank: enabled D flops fed by the arbiter.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.en[i]) bank[i] <= bus.d;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset     = 1'b0;
    bus.req   = 4'b0000;
    bus.addr  = 8'h00;
    bus.wdata = 32'h0;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset state
    tick();
    tick();
    check_val("rst_gnt", 32'(bus.gnt), 32'h0);
    check_val("rst_en", 32'(bus.en), 32'h0);
    check_val("rst_d", 32'(bus.d), 32'h0);
    check_val("rst_cnt", 32'(bus.grant_cnt), 32'h0);
    check_val("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;

    // Single request, then masked follow-up cycle
    bus.req   = 4'b0001;
    bus.addr  = 8'h02;
    bus.wdata = 32'h0000000F;
    #1;
    check_val("single_busy", 32'(bus.busy), 32'h1);
    tick();
    check_val("single_gnt", 32'(bus.gnt), 32'h1);
    check_val("single_en", 32'(bus.en), 32'h4);
    check_val("single_d", 32'(bus.d), 32'h0F);
    check_val("single_cnt", 32'(bus.grant_cnt), 32'h1);
    check_val("single_busy_masked", 32'(bus.busy), 32'h0);
    tick();
    check_val("single_mask_gnt", 32'(bus.gnt), 32'h0);
    check_val("single_mask_en", 32'(bus.en), 32'h0);
    check_val("single_hold_d", 32'(bus.d), 32'h0F);
    check_val("single_hold_cnt", 32'(bus.grant_cnt), 32'h1);
    bus.req = 4'b0000;

    // Fresh reset so round-robin starts at requester 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.req   = 4'b1111;
    bus.addr  = 8'hE4;
    bus.wdata = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("rr_gnt%0d", i), 32'(bus.gnt), 32'(exp_g[i]));
      check_val($sformatf("rr_en%0d", i), 32'(bus.en), 32'(exp_g[i]));
      check_val($sformatf("rr_d%0d", i), 32'(bus.d), 32'(exp_d[i]));
    end
    check_val("rr_cnt", 32'(bus.grant_cnt), 32'd5);
    check_val("rr_sat_cnt", 32'(bus_s.grant_cnt), 32'd5);

    // Pointer resume: grant to 2, then 0101 wraps to 0 before 2
    bus.req = 4'b0100;
    tick();
    check_val("pr_gnt2", 32'(bus.gnt), 32'h4);
    check_val("pr_cnt6", 32'(bus.grant_cnt), 32'd6);
    check_val("pr_sat6", 32'(bus_s.grant_cnt), 32'd6);
    bus.req = 4'b0000;
    tick();
    check_val("pr_idle_gnt", 32'(bus.gnt), 32'h0);
    bus.req = 4'b0101;
    tick();
    check_val("pr_first_gnt", 32'(bus.gnt), 32'h1);
    check_val("pr_first_d", 32'(bus.d), 32'h11);
    check_val("pr_sat7", 32'(bus_s.grant_cnt), 32'd7);
    tick();
    check_val("pr_second_gnt", 32'(bus.gnt), 32'h4);
    check_val("pr_second_d", 32'(bus.d), 32'h33);
    check_val("pr_cnt8", 32'(bus.grant_cnt), 32'd8);
    check_val("pr_sat8", 32'(bus_s.grant_cnt), 32'd7);

    // Same-address serialisation: 0xAA then 0x55 into register 1
    bus.req   = 4'b0011;
    bus.addr  = 8'hE5;
    bus.wdata = 32'h443355AA;
    tick();
    check_val("sa_gnt0", 32'(bus.gnt), 32'h1);
    check_val("sa_en0", 32'(bus.en), 32'h2);
    check_val("sa_d0", 32'(bus.d), 32'hAA);
    check_val("sa_sat9", 32'(bus_s.grant_cnt), 32'd7);
    tick();
    check_val("sa_gnt1", 32'(bus.gnt), 32'h2);
    check_val("sa_en1", 32'(bus.en), 32'h2);
    check_val("sa_d1", 32'(bus.d), 32'h55);
    check_val("sa_bank_first", 32'(bank[1]), 32'hAA);
    check_val("sa_cnt10", 32'(bus.grant_cnt), 32'd10);
    bus.req = 4'b0000;
    tick();
    check_val("sa_idle_en", 32'(bus.en), 32'h0);
    check_val("sa_bank_last", 32'(bank[1]), 32'h55);

    // Asynchronous reset between edges while gnt=0100
    bus.req = 4'b0100;
    tick();
    check_val("ar_pre_gnt", 32'(bus.gnt), 32'h4);
    #2;
    reset = 1'b0;
    #1;
    check_val("ar_gnt", 32'(bus.gnt), 32'h0);
    check_val("ar_en", 32'(bus.en), 32'h0);
    check_val("ar_d", 32'(bus.d), 32'h0);
    check_val("ar_cnt", 32'(bus.grant_cnt), 32'h0);
    check_val("ar_sat_cnt", 32'(bus_s.grant_cnt), 32'h0);
    bus.req   = 4'b1001;
    bus.addr  = 8'hE7;
    bus.wdata = 32'h4433555A;
    tick();
    reset = 1'b1;
    tick();
    check_val("ar_post_gnt", 32'(bus.gnt), 32'h1);
    check_val("ar_post_en", 32'(bus.en), 32'h8);
    check_val("ar_post_d", 32'(bus.d), 32'h5A);
    check_val("ar_post_cnt", 32'(bus.grant_cnt), 32'h1);

    // Lone requester held high: one grant every two cycles
    bus.req = 4'b0001;
    tick();
    check_val("lone_gap_gnt", 32'(bus.gnt), 32'h0);
    tick();
    check_val("lone_again_gnt", 32'(bus.gnt), 32'h1);
    check_val("lone_cnt", 32'(bus.grant_cnt), 32'h2);
    bus.req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
